// File: rtl/spi_master.sv
// SPI mode-0 master: one MSB-first frame of DATA_WIDTH bits per accepted start,
// with SETUP/HOLD/GAP guard phases each CLK_DIV cycles long.
module spi_master #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] txData,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  busy,
  output logic                  done,
  output logic                  spiSclk,
  output logic                  spiCsN,
  output logic                  spiMosi,
  input  logic                  spiMiso
);

  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} stateT;

  stateT                 state, stateNext;
  logic [7:0]            divCnt, divCntNext;
  logic [BW-1:0]         bitCnt, bitCntNext;
  logic [DATA_WIDTH-1:0] txShift, txShiftNext;
  logic [DATA_WIDTH-1:0] rxShift, rxShiftNext;
  logic [DATA_WIDTH-1:0] rxDataNext;
  logic                  busyNext, doneNext, sclkNext, csNNext, mosiNext;
  logic                  divLast, bitLast;

  assign divLast = (divCnt == 8'(CLK_DIV - 1));
  assign bitLast = (bitCnt == BW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = SETUP;
      SETUP:   if (divLast) stateNext = SHIFT;
      SHIFT:   if (divLast && !spiSclk && bitLast) stateNext = HOLD;
      HOLD:    if (divLast) stateNext = GAP;
      GAP:     if (divLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Computes the next value of every output/datapath register so that the
  // SPI pins come straight from flops.
  always_comb begin
    divCntNext  = (state == IDLE || divLast) ? '0 : divCnt + 8'd1;
    bitCntNext  = bitCnt;
    txShiftNext = txShift;
    rxShiftNext = rxShift;
    rxDataNext  = rxData;
    busyNext    = busy;
    doneNext    = 1'b0;
    sclkNext    = spiSclk;
    csNNext     = spiCsN;
    mosiNext    = spiMosi;
    unique case (state)
      IDLE: if (start) begin
        txShiftNext = txData;
        rxShiftNext = '0;
        bitCntNext  = '0;
        busyNext    = 1'b1;
        csNNext     = 1'b0;
        mosiNext    = txData[DATA_WIDTH-1];
      end
      SETUP: if (divLast) begin
        sclkNext    = 1'b1;
        rxShiftNext = {rxShift[DATA_WIDTH-2:0], spiMiso};
      end
      SHIFT: if (divLast) begin
        if (spiSclk) begin
          sclkNext = 1'b0;
          if (!bitLast) begin
            txShiftNext = txShift << 1;
            mosiNext    = txShift[DATA_WIDTH-2];
          end
        end else if (!bitLast) begin
          bitCntNext  = bitCnt + BW'(1);
          sclkNext    = 1'b1;
          rxShiftNext = {rxShift[DATA_WIDTH-2:0], spiMiso};
        end
      end
      HOLD: if (divLast) begin
        csNNext  = 1'b1;
        mosiNext = 1'b0;
      end
      GAP: if (divLast) begin
        busyNext   = 1'b0;
        doneNext   = 1'b1;
        rxDataNext = rxShift;
        bitCntNext = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      divCnt  <= '0;
      bitCnt  <= '0;
      txShift <= '0;
      rxShift <= '0;
      rxData  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      spiSclk <= 1'b0;
      spiCsN  <= 1'b1;
      spiMosi <= 1'b0;
    end else begin
      divCnt  <= divCntNext;
      bitCnt  <= bitCntNext;
      txShift <= txShiftNext;
      rxShift <= rxShiftNext;
      rxData  <= rxDataNext;
      busy    <= busyNext;
      done    <= doneNext;
      spiSclk <= sclkNext;
      spiCsN  <= csNNext;
      spiMosi <= mosiNext;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a default 32-bit/div-4 instance and an
// 8-bit/div-2 instance, both with selectable MISO loopback or tie-high.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rstN;
  logic        startA, startB;
  logic [31:0] txA, rxA;
  logic [7:0]  txB, rxB;
  logic        busyA, doneA, sclkA, csA, mosiA, misoA, tieA;
  logic        busyB, doneB, sclkB, csB, mosiB, misoB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign misoA = tieA ? 1'b1 : mosiA;
  assign misoB = mosiB;

  spi_master dutA (
    .clk(clk), .rstN(rstN), .start(startA), .txData(txA), .rxData(rxA),
    .busy(busyA), .done(doneA), .spiSclk(sclkA), .spiCsN(csA),
    .spiMosi(mosiA), .spiMiso(misoA)
  );

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dutB (
    .clk(clk), .rstN(rstN), .start(startB), .txData(txB), .rxData(rxB),
    .busy(busyB), .done(doneB), .spiSclk(sclkB), .spiCsN(csB),
    .spiMosi(mosiB), .spiMiso(misoB)
  );

  // Statistics gathered by runA, cycle 1 = the cycle after the accepting edge.
  int          doneCnt, busyCnt, rises, mosiBad, mosiHigh, csHighBusy, gapLen, rxChg;
  int          doneCyc [2];
  logic [31:0] rxAt [2];
  logic        firstCs, firstMosi, firstBusy;

  task automatic runA(input logic [31:0] tx1, input logic [31:0] tx2,
                      input int holdUntil, input int p1, input int p2, input int maxCyc);
    logic prevSclk, prevMosi, prevCs;
    logic [31:0] prevRx;
    int curRun;
    doneCnt = 0; busyCnt = 0; rises = 0; mosiBad = 0; mosiHigh = 0;
    csHighBusy = 0; gapLen = -1; rxChg = 0; curRun = 0;
    doneCyc[0] = -1; doneCyc[1] = -1; rxAt[0] = '0; rxAt[1] = '0;
    prevSclk = sclkA; prevMosi = mosiA; prevCs = csA; prevRx = rxA;
    txA = tx1; startA = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= maxCyc; c++) begin
      #1;
      if (c == 1) begin firstCs = csA; firstMosi = mosiA; firstBusy = busyA; end
      if (busyA) busyCnt++;
      if (doneA) begin
        if (doneCnt < 2) begin doneCyc[doneCnt] = c; rxAt[doneCnt] = rxA; end
        doneCnt++;
      end
      if (rxA !== prevRx && !doneA) rxChg++;
      if (sclkA && !prevSclk && !csA) rises++;
      if (!prevCs && !csA && mosiA !== prevMosi && !(prevSclk && !sclkA)) mosiBad++;
      if (mosiA) mosiHigh++;
      if (csA && busyA) csHighBusy++;
      if (csA) curRun++;
      else begin
        if (curRun > 0 && gapLen < 0) gapLen = curRun;
        curRun = 0;
      end
      prevSclk = sclkA; prevMosi = mosiA; prevCs = csA; prevRx = rxA;
      if (c == 2) txA = tx2;
      startA = (c < holdUntil) || (c + 1 == p1) || (c + 1 == p2);
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    rstN = 1'b1; startA = 1'b0; startB = 1'b0; txA = '0; txB = '0; tieA = 1'b0;
    #1 rstN = 1'b0;
    #1;
    checks++;
    if ({busyA, doneA, sclkA, csA, mosiA} !== 5'b00010 || rxA !== 32'h0) begin
      failures++;
      $display("FAIL reset_A: busy/done/sclk/csN/mosi=%b rx=%h, required 00010 rx=0",
               {busyA, doneA, sclkA, csA, mosiA}, rxA);
    end
    checks++;
    if ({busyB, doneB, sclkB, csB, mosiB} !== 5'b00010 || rxB !== 8'h0) begin
      failures++;
      $display("FAIL reset_B: busy/done/sclk/csN/mosi=%b rx=%h, required 00010 rx=0",
               {busyB, doneB, sclkB, csB, mosiB}, rxB);
    end
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback;
    tieA = 1'b0;
    runA(32'hA5C30F81, 32'hA5C30F81, 0, -1, -1, 275);
    checks++;
    if (firstCs !== 1'b0 || firstMosi !== 1'b1 || firstBusy !== 1'b1) begin
      failures++;
      $display("FAIL loop_first_cycle: csN=%b mosi=%b busy=%b, required 0 1 1", firstCs, firstMosi, firstBusy);
    end
    checks++;
    if (doneCnt !== 1 || doneCyc[0] !== 269) begin
      failures++;
      $display("FAIL loop_done: count=%0d cycle=%0d, required 1 at 269", doneCnt, doneCyc[0]);
    end
    checks++;
    if (busyCnt !== 268) begin
      failures++;
      $display("FAIL loop_busy: got %0d cycles, required 268", busyCnt);
    end
    checks++;
    if (rxAt[0] !== 32'hA5C30F81 || rxA !== 32'hA5C30F81) begin
      failures++;
      $display("FAIL loop_rx: done=%h hold=%h, required a5c30f81", rxAt[0], rxA);
    end
    checks++;
    if (rises !== 32) begin
      failures++;
      $display("FAIL loop_rises: got %0d, required 32", rises);
    end
    checks++;
    if (mosiBad !== 0 || rxChg !== 0) begin
      failures++;
      $display("FAIL loop_timing: mosi off-edge changes=%0d rx changes outside done=%0d, required 0 0", mosiBad, rxChg);
    end
  endtask

  task automatic test_miso_ones;
    tieA = 1'b1;
    runA(32'h0, 32'h0, 0, -1, -1, 272);
    checks++;
    if (rxAt[0] !== 32'hFFFFFFFF || doneCyc[0] !== 269) begin
      failures++;
      $display("FAIL ones_rx: got %h at %0d, required ffffffff at 269", rxAt[0], doneCyc[0]);
    end
    checks++;
    if (mosiHigh !== 0) begin
      failures++;
      $display("FAIL ones_mosi: mosi high %0d cycles, required 0", mosiHigh);
    end
    tieA = 1'b0;
  endtask

  task automatic test_small;
    int busyN, doneAt, risesB, badHi, badLo, curHi, lowRun;
    busyN = 0; doneAt = -1; risesB = 0; badHi = 0; badLo = 0; curHi = 0; lowRun = 0;
    txB = 8'h5A; startB = 1'b1;
    @(posedge clk);
    #1 startB = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (busyB) busyN++;
      if (doneB && doneAt < 0) doneAt = c;
      if (sclkB) begin
        if (curHi == 0) begin
          risesB++;
          if (lowRun !== 2) badLo++;
          lowRun = 0;
        end
        curHi++;
      end else begin
        if (curHi > 0 && curHi !== 2) badHi++;
        curHi = 0;
        if (!csB) lowRun++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rxB !== 8'h5A || doneAt !== 39) begin
      failures++;
      $display("FAIL small_rx: got %h done at %0d, required 5a at 39", rxB, doneAt);
    end
    checks++;
    if (busyN !== 38) begin
      failures++;
      $display("FAIL small_busy: got %0d, required 38", busyN);
    end
    checks++;
    if (risesB !== 8 || badHi !== 0 || badLo !== 0) begin
      failures++;
      $display("FAIL small_phases: rises=%0d badHigh=%0d badLow=%0d, required 8 0 0", risesB, badHi, badLo);
    end
  endtask

  task automatic test_ignore_start;
    runA(32'h3C3C00FF, 32'h3C3C00FF, 0, 10, 100, 300);
    checks++;
    if (doneCnt !== 1 || doneCyc[0] !== 269) begin
      failures++;
      $display("FAIL ignore_done: count=%0d cycle=%0d, required 1 at 269", doneCnt, doneCyc[0]);
    end
    checks++;
    if (busyCnt !== 268 || rxAt[0] !== 32'h3C3C00FF) begin
      failures++;
      $display("FAIL ignore_busy: busy=%0d rx=%h, required 268 3c3c00ff", busyCnt, rxAt[0]);
    end
  endtask

  task automatic test_back_to_back;
    runA(32'hC0FFEE11, 32'h0BADF00D, 271, -1, -1, 545);
    checks++;
    if (doneCnt !== 2 || doneCyc[0] !== 269 || doneCyc[1] !== 538) begin
      failures++;
      $display("FAIL b2b_done: count=%0d at %0d,%0d, required 2 at 269,538", doneCnt, doneCyc[0], doneCyc[1]);
    end
    checks++;
    if (rxAt[0] !== 32'hC0FFEE11 || rxAt[1] !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL b2b_rx: got %h,%h, required c0ffee11,0badf00d", rxAt[0], rxAt[1]);
    end
    // GAP keeps CS high for CLK_DIV busy cycles; the done/IDLE cycle adds one more.
    checks++;
    if (csHighBusy !== 8 || gapLen !== 5) begin
      failures++;
      $display("FAIL b2b_gap: csN-high busy cycles=%0d inter-frame run=%0d, required 8 5", csHighBusy, gapLen);
    end
  endtask

  task automatic test_reset_mid;
    int doneSeen;
    doneSeen = 0;
    txA = 32'hDEADBEEF; startA = 1'b1;
    @(posedge clk);
    #1 startA = 1'b0;
    repeat (149) @(posedge clk);
    #1;
    checks++;
    if (sclkA !== 1'b1 || csA !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre: sclk=%b csN=%b, required 1 0", sclkA, csA);
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (csA !== 1'b1 || sclkA !== 1'b0 || busyA !== 1'b0 || rxA !== 32'h0) begin
      failures++;
      $display("FAIL midrst_async: csN=%b sclk=%b busy=%b rx=%h, required 1 0 0 0", csA, sclkA, busyA, rxA);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (doneA) doneSeen++;
    end
    rstN = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (doneA) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0 || rxA !== 32'h0) begin
      failures++;
      $display("FAIL midrst_nodone: done pulses=%0d rx=%h, required 0 0", doneSeen, rxA);
    end
    runA(32'h12345678, 32'h12345678, 0, -1, -1, 272);
    checks++;
    if (rxAt[0] !== 32'h12345678 || doneCyc[0] !== 269) begin
      failures++;
      $display("FAIL midrst_after: rx=%h done at %0d, required 12345678 at 269", rxAt[0], doneCyc[0]);
    end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_miso_ones;
    test_small;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
